// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;

    localparam int REG_AW_DEFAULT = 5;

    // Register x0 is hardwired to zero, so a load targeting it never creates a hazard
    localparam logic [4:0] X0 = 5'd0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MDU_BUSY = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/hazard_perf_counter.sv
// hazard_perf_counter: saturating event counter with synchronous clear
module hazard_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear wins over increment; the count sticks at all-ones instead of wrapping
    always_comb cnt_d = clr_i ? '0 : (inc_i && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;

    // Counter register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for load-use, branch, MDU and memory-wait hazards
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_memread,
    input  logic              ex_branch_taken,
    input  logic              ex_mdu_start,
    input  logic              mdu_done,
    input  logic              mem_req,
    input  logic              mem_ready,
    input  logic              cnt_clr,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_write,
    output logic              idex_flush,
    output logic              exmem_write,
    output logic              exmem_flush,
    output logic              memwb_flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [1:0]        state_o
);

    state_e state_q, state_d;
    logic   busy, lu, mw, dw, hold, kill, lu_stall;

    // MEM_WAIT and the unused encoding behave exactly like RUN; only MDU_BUSY changes the rules
    assign busy = (state_q == ST_MDU_BUSY);
    assign lu   = ex_memread && (ex_rd != REG_AW'(X0)) &&
                  ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
    assign mw   = mem_req && !mem_ready;
    assign dw   = ex_mdu_start && !mdu_done;

    // Hazard classification in priority order: memory wait, MDU hold, branch kill, load-use bubble
    always_comb begin
        hold     = !mw && (busy ? !mdu_done : dw);
        kill     = !busy && !mw && !dw && ex_branch_taken;
        lu_stall = !busy && !mw && !dw && !ex_branch_taken && lu;
        state_d  = mw ? ST_MEM_WAIT : hold ? ST_MDU_BUSY : ST_RUN;
    end

    // Pipeline register controls derived from the active hazard
    always_comb begin
        pc_write    = !(mw || hold || lu_stall);
        ifid_write  = !(mw || hold || lu_stall);
        ifid_flush  = kill;
        idex_write  = !(mw || hold);
        idex_flush  = kill || lu_stall;
        exmem_write = !mw;
        exmem_flush = hold;
        memwb_flush = mw;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= ST_RUN;
        else        state_q <= state_d;

    assign state_o = state_q;

    hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (!pc_write),
        .clr_i (cnt_clr),
        .cnt_o (stall_cnt)
    );

    hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (ifid_flush),
        .clr_i (cnt_clr),
        .cnt_o (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks of hazard controls, FSM state and counters
module tb_pipeline_hazard_ctrl;

    localparam int AW = 5;
    localparam int CW = 4;
    localparam logic [7:0] C_DEF    = 8'hD4;
    localparam logic [7:0] C_LU     = 8'h1C;
    localparam logic [7:0] C_BR     = 8'hFC;
    localparam logic [7:0] C_HOLD   = 8'h06;
    localparam logic [7:0] C_FREEZE = 8'h01;

    logic          clk = 0, rst_n = 0;
    logic [AW-1:0] id_rs1 = 0, id_rs2 = 0, ex_rd = 0;
    logic          id_use_rs1 = 0, id_use_rs2 = 0, ex_memread = 0, ex_branch_taken = 0;
    logic          ex_mdu_start = 0, mdu_done = 0, mem_req = 0, mem_ready = 0, cnt_clr = 0;
    logic          pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
    logic          exmem_write, exmem_flush, memwb_flush;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [1:0]    state_o;
    logic [7:0]    ctl;
    int            checks = 0, errors = 0;

    always #5 clk = ~clk;

    assign ctl = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, exmem_flush, memwb_flush};

    pipeline_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_rd           (ex_rd),
        .ex_memread      (ex_memread),
        .ex_branch_taken (ex_branch_taken),
        .ex_mdu_start    (ex_mdu_start),
        .mdu_done        (mdu_done),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .cnt_clr         (cnt_clr),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_write      (idex_write),
        .idex_flush      (idex_flush),
        .exmem_write     (exmem_write),
        .exmem_flush     (exmem_flush),
        .memwb_flush     (memwb_flush),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .state_o         (state_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_state", state_o, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_flush", flush_cnt, 0);
        chk("rst_ctl", ctl, C_DEF);
        rst_n = 1;
        tick();
        ex_memread = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1; #1;
        chk("lu_ctl", ctl, C_LU);
        tick();
        chk("lu_stall", stall_cnt, 1);
        chk("lu_state", state_o, 0);
        ex_memread = 0; #1;
        chk("lu_gone", ctl, C_DEF);
        ex_memread = 1; ex_rd = 0; id_rs1 = 0; #1;
        chk("lu_x0_ctl", ctl, C_DEF);
        tick();
        chk("lu_x0_stall", stall_cnt, 1);
        ex_rd = 7; id_rs1 = 3; id_rs2 = 7; id_use_rs2 = 0; #1;
        chk("lu_rs2_unused", ctl, C_DEF);
        id_use_rs2 = 1; #1;
        chk("lu_rs2_ctl", ctl, C_LU);
        tick();
        chk("lu_rs2_stall", stall_cnt, 2);
        ex_branch_taken = 1; #1;
        chk("br_lu_ctl", ctl, C_BR);
        tick();
        chk("br_flush", flush_cnt, 1);
        chk("br_stall", stall_cnt, 2);
        ex_branch_taken = 0; ex_memread = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_mdu_start = 1; mdu_done = 1; #1;
        chk("mdu_fast_ctl", ctl, C_DEF);
        tick();
        chk("mdu_fast_state", state_o, 0);
        chk("mdu_fast_stall", stall_cnt, 2);
        mdu_done = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("mdu_hold_ctl", ctl, C_HOLD);
            chk("mdu_hold_state", state_o, (i == 0) ? 0 : 1);
            tick();
        end
        chk("mdu_busy_stall", stall_cnt, 6);
        mdu_done = 1; #1;
        chk("mdu_rel_ctl", ctl, C_DEF);
        chk("mdu_rel_state", state_o, 1);
        tick();
        chk("mdu_back_run", state_o, 0);
        chk("mdu_rel_stall", stall_cnt, 6);
        mdu_done = 0; mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mw_freeze_ctl", ctl, C_FREEZE);
            chk("mw_state", state_o, (i == 0) ? 0 : 2);
            tick();
        end
        chk("mw_stall", stall_cnt, 9);
        mem_ready = 1; #1;
        chk("mw_rel_ctl", ctl, C_HOLD);
        chk("mw_rel_state", state_o, 2);
        tick();
        chk("mw_to_mdu", state_o, 1);
        chk("mw_rel_stall", stall_cnt, 10);
        mem_req = 0; mem_ready = 0; mdu_done = 1; #1;
        chk("mw_mdu_done_ctl", ctl, C_DEF);
        tick();
        chk("mw_mdu_run", state_o, 0);
        ex_mdu_start = 0; mdu_done = 0; mem_req = 1;
        tick();
        chk("arst_pre_state", state_o, 2);
        chk("arst_pre_stall", stall_cnt, 11);
        #1 rst_n = 0;
        #1;
        chk("arst_state", state_o, 0);
        chk("arst_stall", stall_cnt, 0);
        chk("arst_flush", flush_cnt, 0);
        tick();
        chk("arst_hold_state", state_o, 0);
        mem_req = 0; rst_n = 1;
        tick();
        chk("arst_after_state", state_o, 0);
        chk("arst_after_stall", stall_cnt, 0);
        ex_mdu_start = 1; mdu_done = 0;
        repeat (20) tick();
        chk("sat_stall", stall_cnt, 15);
        chk("sat_state", state_o, 1);
        cnt_clr = 1;
        tick();
        chk("clr_stall", stall_cnt, 0);
        cnt_clr = 0;
        tick();
        chk("clr_resume", stall_cnt, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
